// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive bit-timing slice.
//   rx_state_t            : bit-timer FSM state encoding
//   DEFAULT_CLKS_PER_BIT  : system clocks per USB bit period
//   DEFAULT_SAMPLE_PHASE  : bit-period phase at which a bit is sampled
//   DEFAULT_MAX_RUN       : longest legal run of edge-free bits
//   BYTE_BITS             : bits per received byte
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,  // receive window closed
    WAIT_EDGE = 2'd1,  // window open, hunting for the first transition
    RUN       = 2'd2   // locked to the bit clock, strobing samples
  } rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 8;
  localparam int DEFAULT_SAMPLE_PHASE = 3;
  localparam int DEFAULT_MAX_RUN      = 6;
  localparam int BYTE_BITS            = 8;

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear, load and rollover.
// Priority: clear > load > count_enable. On count_enable the counter wraps
// from rollover_value back to 0.
//   clk            : system clock
//   n_rst          : synchronous active-low reset, forces count to 0
//   clear          : synchronous clear to 0
//   count_enable   : advance by one (or wrap) this cycle
//   load           : load load_value this cycle
//   load_value     : value taken on load
//   rollover_value : last value before wrapping to 0
//   count          : current count
module flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] rollover_value,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_next;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (load) begin
      count_next = load_value;
    end else if (count_enable) begin
      count_next = (count == rollover_value) ? '0 : count + WIDTH'(1);
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples its inputs before any of them update within the same edge.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/rx_bit_timer.sv
// USB receive bit timer. Locks a phase counter to transitions on d_plus
// (d_edge), strobes shift_enable once per bit at SAMPLE_PHASE, counts bits
// into bytes and flags bit-stuffing violations (more than MAX_RUN
// consecutive edge-free bits).
//   clk           : system clock
//   n_rst         : synchronous active-low reset
//   enable        : receive window open (held high for a packet)
//   d_edge        : one-cycle pulse on each d_plus transition
//   shift_enable  : one-cycle sample strobe for the shift register
//   byte_received : one-cycle pulse after the 8th strobe of a byte
//   bit_index     : bits already shifted in the current byte, 0..7
//   stuff_err     : one-cycle pulse on a bit-stuffing violation
module rx_bit_timer
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SAMPLE_PHASE = DEFAULT_SAMPLE_PHASE,
  parameter int MAX_RUN      = DEFAULT_MAX_RUN
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       enable,
  input  logic       d_edge,
  output logic       shift_enable,
  output logic       byte_received,
  output logic [2:0] bit_index,
  output logic       stuff_err
);

  localparam int PHASE_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int RUN_W   = (MAX_RUN > 0) ? $clog2(MAX_RUN + 1) : 1;

  localparam logic [PHASE_W-1:0] SAMPLE_AT  = PHASE_W'(SAMPLE_PHASE);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(CLKS_PER_BIT - 1);
  // The edge cycle itself is phase 0, so the counter resumes at 1.
  localparam logic [PHASE_W-1:0] RESYNC_PHASE = PHASE_W'(1);
  localparam logic [RUN_W-1:0]   RUN_LIMIT  = RUN_W'(MAX_RUN);
  localparam logic [2:0]         LAST_BIT   = 3'(BYTE_BITS - 1);

  rx_state_t          state;
  rx_state_t          state_next;
  logic [PHASE_W-1:0] phase;
  logic [RUN_W-1:0]   run_len;
  logic [RUN_W-1:0]   run_len_next;
  logic [2:0]         bit_index_next;
  logic               edge_seen;
  logic               edge_seen_next;
  logic               byte_received_next;
  logic               stuff_err_next;
  logic               edge_hit;
  logic               violation;
  logic               phase_clear;
  logic               phase_load;
  logic               phase_count;

  flex_counter #(
    .WIDTH(PHASE_W)
  ) u_phase (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (phase_clear),
    .count_enable  (phase_count),
    .load          (phase_load),
    .load_value    (RESYNC_PHASE),
    .rollover_value(LAST_PHASE),
    .count         (phase)
  );

  // Moore strobe: depends only on registered state and phase.
  assign shift_enable = (state == RUN) && (phase == SAMPLE_AT);

  // An edge arriving on the strobe cycle still belongs to the bit being
  // sampled, so it is merged with the edge_seen flag here.
  assign edge_hit  = edge_seen | d_edge;
  assign violation = shift_enable && !edge_hit && (run_len == RUN_LIMIT);

  always_comb begin
    state_next         = state;
    bit_index_next     = bit_index;
    run_len_next       = run_len;
    edge_seen_next     = edge_seen;
    byte_received_next = 1'b0;
    stuff_err_next     = 1'b0;
    phase_clear        = 1'b0;
    phase_load         = 1'b0;
    phase_count        = 1'b0;

    if (!enable) begin
      // Closing the window abandons any partial byte.
      state_next     = IDLE;
      bit_index_next = '0;
      run_len_next   = '0;
      edge_seen_next = 1'b0;
      phase_clear    = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          state_next  = WAIT_EDGE;
          phase_clear = 1'b1;
        end

        WAIT_EDGE: begin
          if (d_edge) begin
            state_next     = RUN;
            phase_load     = 1'b1;
            edge_seen_next = 1'b1;  // the sync edge counts for the first bit
          end else begin
            phase_clear = 1'b1;
          end
        end

        RUN: begin
          phase_count = 1'b1;
          phase_load  = d_edge;  // resync overrides increment and wrap
          if (shift_enable) begin
            edge_seen_next = 1'b0;
            if (violation) begin
              // Lost lock: drop the byte in progress and hunt again.
              state_next     = WAIT_EDGE;
              stuff_err_next = 1'b1;
              bit_index_next = '0;
              run_len_next   = '0;
              phase_clear    = 1'b1;
            end else begin
              run_len_next       = edge_hit ? '0 : run_len + RUN_W'(1);
              bit_index_next     = bit_index + 3'd1;
              byte_received_next = (bit_index == LAST_BIT);
            end
          end else if (d_edge) begin
            edge_seen_next = 1'b1;
          end
        end

        default: begin
          state_next  = IDLE;
          phase_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state         <= IDLE;
      bit_index     <= '0;
      run_len       <= '0;
      edge_seen     <= 1'b0;
      byte_received <= 1'b0;
      stuff_err     <= 1'b0;
    end else begin
      state         <= state_next;
      bit_index     <= bit_index_next;
      run_len       <= run_len_next;
      edge_seen     <= edge_seen_next;
      byte_received <= byte_received_next;
      stuff_err     <= stuff_err_next;
    end
  end

endmodule

// File: tb/tb_rx_bit_timer.sv
// Self-checking bench for rx_bit_timer (CLKS_PER_BIT=8, SAMPLE_PHASE=3,
// MAX_RUN=6). A timestamp-based protocol model predicts every output each
// cycle; directed scenarios add literal expectations on logged events.
module tb_rx_bit_timer;
  import usb_rx_pkg::*;

  localparam int CPB  = 8;
  localparam int SP   = 3;
  localparam int MR   = 6;
  localparam int LOGN = 4096;

  logic       clk    = 1'b0;
  logic       n_rst  = 1'b0;
  logic       enable = 1'b0;
  logic       d_edge = 1'b0;
  logic       shift_enable;
  logic       byte_received;
  logic [2:0] bit_index;
  logic       stuff_err;

  rx_bit_timer #(
    .CLKS_PER_BIT(CPB),
    .SAMPLE_PHASE(SP),
    .MAX_RUN     (MR)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable       (enable),
    .d_edge       (d_edge),
    .shift_enable (shift_enable),
    .byte_received(byte_received),
    .bit_index    (bit_index),
    .stuff_err    (stuff_err)
  );

  always #5 clk = ~clk;

  // Cycle c is the interval following the posedge at which cyc becomes c.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Observed DUT events per cycle, for the literal scenario checks.
  bit se_log [LOGN];
  bit br_log [LOGN];
  bit st_log [LOGN];

  function automatic int count_log(input int which, input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) begin
      if (i >= 0 && i < LOGN) begin
        if (which == 0 && se_log[i]) n++;
        if (which == 1 && br_log[i]) n++;
        if (which == 2 && st_log[i]) n++;
      end
    end
    return n;
  endfunction

  // Protocol model: phase is derived from the distance to the last edge.
  bit listening = 1'b0;  // window open for at least one cycle
  bit synced    = 1'b0;  // locked to an edge
  bit edge_pend = 1'b0;  // an edge has occurred since the last sample
  bit exp_br    = 1'b0;
  bit exp_st    = 1'b0;
  bit m_strobe;
  bit m_had;
  int last_edge = 0;
  int quiet     = 0;     // consecutive edge-free samples
  int bits      = 0;     // bits held in the current byte

  always @(negedge clk) begin
    m_strobe = synced && (cyc > last_edge) && (((cyc - last_edge) % CPB) == SP);
    if (cyc < LOGN) begin
      se_log[cyc] = shift_enable;
      br_log[cyc] = byte_received;
      st_log[cyc] = stuff_err;
    end
    if (cyc >= 1) begin
      check("shift_enable", 32'(shift_enable), 32'(m_strobe));
      check("byte_received", 32'(byte_received), 32'(exp_br));
      check("stuff_err", 32'(stuff_err), 32'(exp_st));
      check("bit_index", 32'(bit_index), 32'(bits));
    end
    // Advance the model with this cycle's inputs.
    exp_br = 1'b0;
    exp_st = 1'b0;
    if (!n_rst || !enable) begin
      listening = 1'b0;
      synced    = 1'b0;
      edge_pend = 1'b0;
      quiet     = 0;
      bits      = 0;
    end else if (!listening) begin
      listening = 1'b1;
    end else if (!synced) begin
      if (d_edge) begin
        synced    = 1'b1;
        last_edge = cyc;
        edge_pend = 1'b1;
      end
    end else begin
      if (m_strobe) begin
        m_had     = edge_pend || d_edge;
        edge_pend = 1'b0;
        if (!m_had && quiet == MR) begin
          exp_st = 1'b1;
          synced = 1'b0;
          quiet  = 0;
          bits   = 0;
        end else begin
          quiet = m_had ? 0 : quiet + 1;
          bits  = bits + 1;
          if (bits == 8) begin
            bits   = 0;
            exp_br = 1'b1;
          end
        end
      end else if (d_edge) begin
        edge_pend = 1'b1;
      end
      if (d_edge) last_edge = cyc;
    end
  end

  task automatic tick(input logic r, input logic e, input logic d);
    @(posedge clk);
    #1;
    n_rst  = r;
    enable = e;
    d_edge = d;
  endtask

  task automatic quiet_cycles(input int n);
    repeat (n) tick(1'b1, 1'b1, 1'b0);
  endtask

  task automatic pulse(output int at);
    tick(1'b1, 1'b1, 1'b1);
    at = cyc;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int s0, e0, last, t1, t2, e3, f, g, g0, h0, dummy;

  initial begin
    // Reset held from time zero.
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    settle();
    check("reset_shift_enable", 32'(shift_enable), 0);
    check("reset_bit_index", 32'(bit_index), 0);
    check("reset_state", 32'(dut.state), 32'(IDLE));

    // Steady stream: enable, first edge 10 cycles later, edges every 8.
    tick(1'b1, 1'b1, 1'b0);
    s0 = cyc;
    quiet_cycles(9);
    pulse(e0);
    for (int k = 1; k <= 8; k++) begin
      quiet_cycles(7);
      pulse(last);
    end
    settle();
    check("s1_strobe_at_13", 32'(se_log[s0 + 13]), 1);
    check("s1_no_early_strobe", count_log(0, s0, s0 + 12), 0);
    check("s1_strobe_at_21", 32'(se_log[s0 + 21]), 1);
    check("s1_strobe_at_29", 32'(se_log[s0 + 29]), 1);
    check("s1_byte_at_70", 32'(br_log[s0 + 70]), 1);
    check("s1_byte_count", count_log(1, s0, s0 + 70), 1);

    // Drift: early edge at phase 7, then a late edge at phase 1.
    quiet_cycles(6);
    pulse(t1);
    quiet_cycles(8);
    pulse(t2);
    quiet_cycles(3);
    settle();
    check("drift_early_strobe", 32'(se_log[t1 + 3]), 1);
    check("drift_stale_strobe", 32'(se_log[t1 + 11]), 0);
    check("drift_late_strobe", 32'(se_log[t2 + 3]), 1);
    check("drift_strobe_count", count_log(0, t1, t2 + 3), 2);

    // Six edge-free bits, then an edge: legal.
    quiet_cycles(52);
    settle();
    check("run6_len", 32'(dut.run_len), 6);
    pulse(e3);
    quiet_cycles(4);
    settle();
    check("run6_no_stuff", count_log(2, t2, e3 + 4), 0);
    check("run6_strobe", 32'(se_log[e3 + 3]), 1);
    check("run6_len_cleared", 32'(dut.run_len), 0);

    // Seven edge-free bits: stuffing violation.
    quiet_cycles(58);
    settle();
    check("run7_seventh_strobe", 32'(se_log[e3 + 59]), 1);
    check("run7_stuff_not_early", 32'(st_log[e3 + 59]), 0);
    check("run7_stuff_pulse", 32'(st_log[e3 + 60]), 1);
    check("run7_stuff_count", count_log(2, e3, e3 + 62), 1);
    check("run7_no_byte", 32'(br_log[e3 + 60]), 0);
    check("run7_state", 32'(dut.state), 32'(WAIT_EDGE));
    check("run7_bit_index", 32'(bit_index), 0);

    // Edge coincident with the strobe.
    pulse(f);
    quiet_cycles(10);
    pulse(g);
    quiet_cycles(1);
    settle();
    check("coinc_strobe", 32'(se_log[f + 11]), 1);
    check("coinc_run_len", 32'(dut.run_len), 0);
    quiet_cycles(3);
    settle();
    check("coinc_next_strobe", 32'(se_log[f + 14]), 1);
    check("coinc_strobe_count", count_log(0, f + 12, f + 15), 1);

    // Enable dropped with five bits in the byte.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    quiet_cycles(2);
    pulse(g0);
    for (int k = 1; k <= 4; k++) begin
      quiet_cycles(7);
      pulse(dummy);
    end
    quiet_cycles(4);
    settle();
    check("drop_bit_index_5", 32'(bit_index), 5);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    settle();
    check("drop_state", 32'(dut.state), 32'(IDLE));
    check("drop_bit_index", 32'(bit_index), 0);
    check("drop_shift_enable", 32'(shift_enable), 0);
    for (int k = 0; k < 20; k++) tick(1'b1, 1'b0, (k % 8) == 0);
    settle();
    check("drop_no_byte", count_log(1, g0, cyc), 0);

    // Reset asserted with five bits in the byte.
    tick(1'b1, 1'b1, 1'b0);
    quiet_cycles(2);
    pulse(h0);
    for (int k = 1; k <= 4; k++) begin
      quiet_cycles(7);
      pulse(dummy);
    end
    quiet_cycles(4);
    settle();
    check("rst_bit_index_5", 32'(bit_index), 5);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    settle();
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_bit_index", 32'(bit_index), 0);
    check("rst_outputs", {29'd0, shift_enable, byte_received, stuff_err}, 0);
    quiet_cycles(3);
    pulse(dummy);
    quiet_cycles(20);
    settle();
    check("rst_no_byte", count_log(1, h0, cyc), 0);
    check("rst_resync_strobe", 32'(se_log[dummy + 3]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_bit_timer.md
RX_BIT_TIMER -- requirements
Module: rx_bit_timer

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 8, meaning system clocks per USB bit period.
REQ-002 The block SHALL have parameter SAMPLE_PHASE, default 3, meaning the bit-period phase at which a bit is sampled (0 < SAMPLE_PHASE < CLKS_PER_BIT).
REQ-003 The block SHALL have parameter MAX_RUN, default 6, meaning the maximum legal number of consecutive edge-free bits.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 n_rst  input  1  reset, synchronous, active-low.
REQ-006 enable  input  1  receive window active; the controller drives it high for the duration of a packet.
REQ-007 d_edge  input  1  one-cycle pulse marking a transition on d_plus, from the edge detector.
REQ-008 shift_enable  output  1  one-cycle strobe; the receive shift register samples on it.
REQ-009 byte_received  output  1  one-cycle pulse after the 8th shift_enable of a byte.
REQ-010 bit_index  output  3  number of bits already shifted in the current byte, 0..7.
REQ-011 stuff_err  output  1  one-cycle pulse on a bit-stuffing violation.

Function
REQ-012 The FSM SHALL have the states IDLE, WAIT_EDGE and RUN.
REQ-013 In any state, enable=0 SHALL force IDLE on the next cycle and clear phase, bit_index, run_len and edge_seen.
REQ-014 IDLE SHALL go to WAIT_EDGE when enable=1.
REQ-015 WAIT_EDGE SHALL go to RUN with phase=1 on d_edge=1; phase SHALL hold 0 otherwise.
REQ-016 Phase counting: the cycle in which d_edge=1 is phase 0; in RUN the phase SHALL increment each cycle and wrap from CLKS_PER_BIT-1 to 0.
REQ-017 Resync: in RUN, d_edge=1 SHALL load phase=1 on the next cycle, overriding the increment and the wrap.
REQ-018 shift_enable SHALL be a Moore output, high exactly when state=RUN and phase=SAMPLE_PHASE, giving a latency of SAMPLE_PHASE cycles from the resync edge.
REQ-019 The edge_seen flag SHALL set on d_edge and clear on each shift_enable cycle.
REQ-020 At each shift_enable, if edge_seen or d_edge is 1, then run_len SHALL load 0; otherwise run_len SHALL increment.
REQ-021 A d_edge coincident with shift_enable SHALL count toward that sample and SHALL also resync the phase.
REQ-022 If run_len=MAX_RUN and shift_enable occurs with no edge, the block SHALL pulse stuff_err for one cycle (the next cycle).
REQ-023 On that violation the block SHALL go to WAIT_EDGE, clear bit_index and run_len, and suppress byte_received for that bit.
REQ-024 bit_index SHALL increment on each non-error shift_enable and wrap from 7 to 0.
REQ-025 The wrap of bit_index from 7 to 0 SHALL pulse byte_received on the next cycle (registered).
REQ-026 Counters SHALL be sized to ceil(log2(CLKS_PER_BIT)) and ceil(log2(MAX_RUN+1)) bits, unsigned, with no overflow beyond the limits stated above.

Reset
REQ-027 With n_rst=0 at a clock edge, the block SHALL enter IDLE, with phase, run_len and bit_index at 0 and edge_seen at 0.
REQ-028 While held in reset, shift_enable, byte_received and stuff_err SHALL be 0 and bit_index SHALL be 0.
REQ-029 Reset asserted mid-byte SHALL discard the partial byte with no byte_received pulse.

Structure
REQ-030 Package usb_rx_pkg SHALL hold the state enum type, the CLKS_PER_BIT and MAX_RUN defaults, and the byte width constant 8.
REQ-031 The phase counter SHALL be a sub-module, flex_counter, with sync clear, count enable, load-value and rollover value.
REQ-032 The FSM, run-length tracking and bit counting SHALL reside in rx_bit_timer.

Verification
REQ-033 Scenario: enable=1, first d_edge at cycle 10, edges every 8 cycles -> shift_enable at cycles 13, 21, 29, ...; byte_received at cycle 70.
REQ-034 Scenario: edge drift, an edge at phase 7 (early) and one at phase 1 (late) -> the next shift_enable is exactly 3 cycles after each edge; there is no missed or doubled strobe.
REQ-035 Scenario: 6 edge-free bits, then an edge -> no stuff_err and run_len returns to 0.
REQ-036 Scenario: 7 edge-free bits -> stuff_err=1 one cycle after the 7th strobe, state WAIT_EDGE, bit_index=0, no byte_received.
REQ-037 Scenario: d_edge coincident with shift_enable -> the strobe still fires, the next strobe is 3 cycles later, and run_len=0.
REQ-038 Scenario: enable dropped at bit_index=5 (and separately n_rst=0 mid-byte) -> IDLE on the next cycle, all outputs 0, no byte_received.
